// File: rtl/zx_io_pkg.sv
// Shared channel tags, payload widths, config bit positions, receiver state
// type and segment bit routing for the ZX SPI I/O hub.
package zx_io_pkg;

    localparam logic [7:0] CH_CONFIG = 8'd0;
    localparam logic [7:0] CH_MOUSE  = 8'd1;
    localparam logic [7:0] CH_KMPST  = 8'd2;
    localparam logic [7:0] CH_KBD    = 8'd3;

    localparam logic [5:0] W_CONFIG = 6'd8;
    localparam logic [5:0] W_MOUSE  = 6'd24;
    localparam logic [5:0] W_KMPST  = 6'd8;
    localparam logic [5:0] W_KBD    = 6'd40;

    localparam int PAYLOAD_W    = 40;
    localparam int CFG_MOUSE_EN = 0;
    localparam int CFG_KBD_EN   = 1;
    localparam int CFG_WAIT     = 7;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_SHIFT  = 2'd1,
        RX_COMMIT = 2'd2
    } rx_state_e;

    // Zero marks a tag with no channel behind it, so it can never match a count.
    function automatic logic [5:0] chan_width(input logic [7:0] tag);
        case (tag)
            CH_CONFIG: chan_width = W_CONFIG;
            CH_MOUSE:  chan_width = W_MOUSE;
            CH_KMPST:  chan_width = W_KMPST;
            CH_KBD:    chan_width = W_KBD;
            default:   chan_width = 6'd0;
        endcase
    endfunction

    // Bus bits {h,g,f,e,d,c,b,a} land on SEGMENT bits {2,6,7,5,4,3,1,0}.
    function automatic logic [7:0] seg_map(input logic [7:0] d);
        seg_map = {d[5], d[6], d[4], d[3], d[2], d[7], d[1], d[0]};
    endfunction

endpackage

// File: rtl/zx_spi_frame_rx.sv
// Oversampled SPI frame receiver: synchronises the link, shifts bits in, and
// flags a one-cycle commit or error when the frame closes.
module zx_spi_frame_rx
    import zx_io_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TAG_W       = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 sck_i,
    input  logic                 nss_i,
    input  logic                 mosi_i,
    input  logic [TAG_W-1:0]     tag_i,
    output logic                 commit_o,
    output logic                 err_o,
    output logic [TAG_W-1:0]     tag_o,
    output logic [PAYLOAD_W-1:0] payload_o
);

    logic [SYNC_STAGES-1:0]            sck_sync_q, nss_sync_q, mosi_sync_q;
    logic [SYNC_STAGES-1:0][TAG_W-1:0] tag_sync_q;
    logic                              sck_prev_q, nss_prev_q;
    logic                              sck_s, nss_s, mosi_s;
    logic [TAG_W-1:0]                  tag_s;
    logic                              sck_rise, nss_fall, nss_rise;

    rx_state_e            state_q, state_d;
    logic [5:0]           cnt_q, cnt_d;
    logic [PAYLOAD_W-1:0] shreg_q, shreg_d;
    logic [TAG_W-1:0]     tag_q, tag_d;
    logic [5:0]           width;
    logic                 frame_ok;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sck_sync_q  <= '0;
            nss_sync_q  <= '1;
            mosi_sync_q <= '0;
            tag_sync_q  <= '0;
            sck_prev_q  <= 1'b0;
            nss_prev_q  <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
            nss_sync_q  <= {nss_sync_q[SYNC_STAGES-2:0], nss_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            tag_sync_q  <= {tag_sync_q[SYNC_STAGES-2:0], tag_i};
            sck_prev_q  <= sck_s;
            nss_prev_q  <= nss_s;
        end
    end

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign nss_s    = nss_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign tag_s    = tag_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s && !sck_prev_q;
    assign nss_fall = !nss_s && nss_prev_q;
    assign nss_rise = nss_s && !nss_prev_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        tag_d   = tag_q;
        case (state_q)
            RX_IDLE: begin
                if (nss_fall) begin
                    state_d = RX_SHIFT;
                    cnt_d   = '0;
                    shreg_d = '0;
                    tag_d   = tag_s;
                end
            end
            RX_SHIFT: begin
                if (sck_rise) begin
                    shreg_d = {shreg_q[PAYLOAD_W-2:0], mosi_s};
                    if (cnt_q != 6'd63) cnt_d = cnt_q + 6'd1;
                end
                if (nss_rise) state_d = RX_COMMIT;
            end
            RX_COMMIT: state_d = RX_IDLE;
            default:   state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            tag_q   <= tag_d;
        end
    end

    assign width     = chan_width(8'(tag_q));
    assign frame_ok  = (width != 6'd0) && (cnt_q == width);
    assign commit_o  = (state_q == RX_COMMIT) && frame_ok;
    assign err_o     = (state_q == RX_COMMIT) && !frame_ok;
    assign tag_o     = tag_q;
    assign payload_o = shreg_q;

endmodule

// File: rtl/zx_spi_io_hub.sv
// ZX-bus I/O expander: SPI-fed shadow registers served on Z80 port reads,
// plus a glitch-filtered 7-segment output port. Define ZX_SPI_WAIT_EN for WAIT.
module zx_spi_io_hub
    import zx_io_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter int          NCH         = 4,
    parameter int          ERR_W       = 4,
    parameter logic [15:0] SEG_MASK    = 16'h0882,
    parameter logic [15:0] SEG_MATCH   = 16'h0000,
    parameter int          KBD_INVERT  = 1
) (
    input  logic                     CLK14M,
    input  logic                     RESET_N,
    input  logic [15:0]              ADR,
    inout  wire  [7:0]               DATA,
    input  logic                     IORQ,
    input  logic                     RD,
    input  logic                     WR,
    input  logic                     OIRQ,
    output logic                     IORQGE,
    input  logic                     SPI_SCK,
    input  logic                     SPI_NSS,
    input  logic                     SPI_MOSI,
    input  logic [$clog2(NCH)-1:0]   SPI_A,
    output logic [7:0]               SEGMENT,
    output logic [ERR_W-1:0]         FRAME_ERR
`ifdef ZX_SPI_WAIT_EN
    ,
    output wire                      WAIT
`endif
);

    localparam int TAG_W = $clog2(NCH);

    logic                 rx_commit, rx_err;
    logic [TAG_W-1:0]     rx_tag;
    logic [PAYLOAD_W-1:0] rx_payload;
    logic [7:0]           tag8;

    logic [7:0]           cfg_q, kmp_q;
    logic [23:0]          mouse_q;
    logic [39:0]          kbd_q;
    logic [ERR_W-1:0]     err_q;

    logic [SYNC_STAGES-1:0] iorq_sync_q, rd_sync_q, wr_sync_q;
    logic                   iorq_s, rd_s, wr_s;

    logic       seg_hit, seg_hit_q, seg_done_q;
    logic [7:0] seg_q;

    logic       kemp_sel, mouse_sel, kbd_sel;
    logic [7:0] rd_data;
    logic [4:0] kbd_row;

    zx_spi_frame_rx #(
        .SYNC_STAGES (SYNC_STAGES),
        .TAG_W       (TAG_W)
    ) u_rx (
        .clk_i     (CLK14M),
        .rst_ni    (RESET_N),
        .sck_i     (SPI_SCK),
        .nss_i     (SPI_NSS),
        .mosi_i    (SPI_MOSI),
        .tag_i     (SPI_A),
        .commit_o  (rx_commit),
        .err_o     (rx_err),
        .tag_o     (rx_tag),
        .payload_o (rx_payload)
    );

    assign tag8 = 8'(rx_tag);

    // Whole-register writes keep each shadow atomic with respect to Z80 reads.
    always_ff @(posedge CLK14M or negedge RESET_N) begin
        if (!RESET_N) begin
            cfg_q   <= '0;
            mouse_q <= '0;
            kmp_q   <= '0;
            kbd_q   <= (KBD_INVERT != 0) ? '1 : '0;
            err_q   <= '0;
        end else begin
            if (rx_commit) begin
                case (tag8)
                    CH_CONFIG: cfg_q   <= rx_payload[7:0];
                    CH_MOUSE:  mouse_q <= rx_payload[23:0];
                    CH_KMPST:  kmp_q   <= rx_payload[7:0];
                    CH_KBD:    kbd_q   <= (KBD_INVERT != 0) ? ~rx_payload : rx_payload;
                    default:   ;
                endcase
            end
            if (rx_err && (err_q != '1)) err_q <= err_q + ERR_W'(1);
        end
    end

    always_ff @(posedge CLK14M or negedge RESET_N) begin
        if (!RESET_N) begin
            iorq_sync_q <= '1;
            rd_sync_q   <= '1;
            wr_sync_q   <= '1;
        end else begin
            iorq_sync_q <= {iorq_sync_q[SYNC_STAGES-2:0], IORQ};
            rd_sync_q   <= {rd_sync_q[SYNC_STAGES-2:0], RD};
            wr_sync_q   <= {wr_sync_q[SYNC_STAGES-2:0], WR};
        end
    end

    assign iorq_s = iorq_sync_q[SYNC_STAGES-1];
    assign rd_s   = rd_sync_q[SYNC_STAGES-1];
    assign wr_s   = wr_sync_q[SYNC_STAGES-1];

    // A hit must be seen on two consecutive clocks, and only re-arms once it drops.
    assign seg_hit = ((ADR & SEG_MASK) == SEG_MATCH) && !iorq_s && !wr_s;

    always_ff @(posedge CLK14M or negedge RESET_N) begin
        if (!RESET_N) begin
            seg_hit_q  <= 1'b0;
            seg_done_q <= 1'b0;
            seg_q      <= '0;
        end else begin
            seg_hit_q <= seg_hit;
            if (seg_hit && seg_hit_q && !seg_done_q) begin
                seg_q      <= seg_map(DATA);
                seg_done_q <= 1'b1;
            end else if (!seg_hit) begin
                seg_done_q <= 1'b0;
            end
        end
    end

    assign SEGMENT   = seg_q;
    assign FRAME_ERR = err_q;

    always_comb begin
        kbd_row = 5'b11111;
        for (int k = 0; k < 8; k++) begin
            if (!ADR[8+k]) begin
                kbd_row = kbd_row & {kbd_q[32+k], kbd_q[24+k], kbd_q[16+k], kbd_q[8+k], kbd_q[k]};
            end
        end
    end

    always_comb begin
        kemp_sel  = (ADR[7:5] == 3'b000) && !OIRQ && !rd_s;
        mouse_sel = 1'b0;
        kbd_sel   = 1'b0;
        rd_data   = '0;
        if (kemp_sel) begin
            rd_data = kmp_q;
        end else if (!iorq_s && !rd_s && (ADR[7:0] == 8'hDF) && cfg_q[CFG_MOUSE_EN]) begin
            case (ADR[15:8])
                8'hFA: begin mouse_sel = 1'b1; rd_data = mouse_q[7:0];   end
                8'hFB: begin mouse_sel = 1'b1; rd_data = mouse_q[15:8];  end
                8'hFF: begin mouse_sel = 1'b1; rd_data = mouse_q[23:16]; end
                default: ;
            endcase
        end
        if (!kemp_sel && !mouse_sel && !iorq_s && !rd_s && !ADR[0] && cfg_q[CFG_KBD_EN]) begin
            kbd_sel = 1'b1;
            rd_data = {3'b000, kbd_row};
        end
    end

    assign DATA[4:0] = (kemp_sel || mouse_sel || kbd_sel) ? rd_data[4:0] : 5'bz;
    assign DATA[7:5] = (kemp_sel || mouse_sel) ? rd_data[7:5] : 3'bz;
    assign IORQGE    = mouse_sel || kbd_sel;

`ifdef ZX_SPI_WAIT_EN
    logic wait_req;

    // Stall a read that would land on the very cycle its channel is rewritten.
    always_comb begin
        wait_req = cfg_q[CFG_WAIT];
        if ((rx_commit || rx_err) &&
            ((kemp_sel && tag8 == CH_KMPST) ||
             (mouse_sel && tag8 == CH_MOUSE) ||
             (kbd_sel && tag8 == CH_KBD))) begin
            wait_req = 1'b1;
        end
    end

    assign WAIT = wait_req ? 1'b0 : 1'bz;
`endif

endmodule
